// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and constants for the Tetris piece-movement logic.
//   state_t  : movement FSM states
//   KEY_*    : PS/2 set-2 make codes for the game controls
//   PS2_*    : PS/2 prefix bytes (break 8'hF0, extended 8'hE0)
//   rot_t    : 2-bit piece rotation, wraps 3 -> 0
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_COMMIT = 3'd2,
    ST_LOCK   = 3'd3,
    ST_PAUSE  = 3'd4
  } state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT = 8'h2B;
  localparam logic [7:0] KEY_DOWN  = 8'h23;
  localparam logic [7:0] KEY_ROT   = 8'h3C;
  localparam logic [7:0] KEY_PAUSE = 8'h1B;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef logic [1:0] rot_t;

endpackage

// File: rtl/tetris_gravity_timer.sv
// tetris_gravity_timer: free-running drop timer for automatic piece descent.
// Counts 0..GRAVITY_TICKS-1 while enable is high and holds its value while
// enable is low. tick is high for the one cycle in which the count wraps.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high reset (count returns to 0)
//   enable : count advances only while high
//   tick   : one-cycle strobe on wrap
module tetris_gravity_timer #(
  parameter int GRAVITY_TICKS = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GRAVITY_TICKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/tetris_move_fsm.sv
// tetris_move_fsm: piece-movement controller.
// Turns PS/2 make codes (and, with TETRIS_GRAVITY_EN defined, a periodic
// gravity tick) into candidate moves, asks the collision checker for approval,
// then commits the move or locks the piece and respawns it.
// Optional feature macro: TETRIS_GRAVITY_EN (automatic drop every
// GRAVITY_TICKS cycles; without it pieces descend only on the down key).
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   key_valid, key_code  : one-cycle strobe with a PS/2 set-2 byte
//   check_req            : candidate valid, held until check_ack
//   cand_x/cand_y/cand_rot : candidate position, stable while check_req
//   check_ack, check_ok  : checker response; check_ok sampled only with ack
//   xpos/ypos/rot        : committed piece position
//   lock_pulse           : one cycle, piece locked at xpos/ypos/rot
//   paused               : game paused
//   busy                 : not idle; move keys are dropped
//   state_dbg            : current FSM state (debug visibility)
// Handshake: check_req rises with a candidate and stays high with cand_*
// unchanged until the first cycle check_ack is sampled high; check_ack
// seen while check_req is low has no effect.
module tetris_move_fsm
  import tetris_pkg::*;
#(
  parameter int COLS          = 10,
  parameter int ROWS          = 20,
  parameter int SPAWN_X       = 4,
  parameter int GRAVITY_TICKS = 50_000_000,
  parameter int XW            = $clog2(COLS),
  parameter int YW            = $clog2(ROWS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [7:0]    key_code,
  output logic          check_req,
  output logic [XW-1:0] cand_x,
  output logic [YW-1:0] cand_y,
  output logic [1:0]    cand_rot,
  input  logic          check_ack,
  input  logic          check_ok,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic [1:0]    rot,
  output logic          lock_pulse,
  output logic          paused,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  localparam logic [XW-1:0] X_MAX   = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_SPAWN = XW'(SPAWN_X);

  state_t        state, state_n;
  logic [XW-1:0] xpos_n, cand_x_n;
  logic [YW-1:0] ypos_n, cand_y_n;
  rot_t          rot_n, cand_rot_n;
  logic          cand_down, cand_down_n;
  logic          break_flag, break_n;
  logic          grav_pending, pend_n;
  logic          grav_tick;
  logic          byte_ok;
  logic          want_down;

`ifdef TETRIS_GRAVITY_EN
  logic grav_enable;
  assign grav_enable = (state != ST_PAUSE);

  tetris_gravity_timer #(
    .GRAVITY_TICKS(GRAVITY_TICKS)
  ) u_gravity (
    .clock  (clock),
    .reset  (reset),
    .enable (grav_enable),
    .tick   (grav_tick)
  );
`else
  logic gravity_cfg_unused;
  assign grav_tick          = 1'b0;
  assign gravity_cfg_unused = (GRAVITY_TICKS == 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      xpos         <= X_SPAWN;
      ypos         <= '0;
      rot          <= '0;
      cand_x       <= '0;
      cand_y       <= '0;
      cand_rot     <= '0;
      cand_down    <= 1'b0;
      break_flag   <= 1'b0;
      grav_pending <= 1'b0;
    end else begin
      state        <= state_n;
      xpos         <= xpos_n;
      ypos         <= ypos_n;
      rot          <= rot_n;
      cand_x       <= cand_x_n;
      cand_y       <= cand_y_n;
      cand_rot     <= cand_rot_n;
      cand_down    <= cand_down_n;
      break_flag   <= break_n;
      grav_pending <= pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    xpos_n      = xpos;
    ypos_n      = ypos;
    rot_n       = rot;
    cand_x_n    = cand_x;
    cand_y_n    = cand_y;
    cand_rot_n  = cand_rot;
    cand_down_n = cand_down;
    break_n     = break_flag;
    pend_n      = grav_pending;
    byte_ok     = 1'b0;
    want_down   = 1'b0;

    // Prefix filtering runs in every state so a break code that arrives
    // while busy still swallows the following byte.
    if (key_valid) begin
      if (break_flag) begin
        break_n = 1'b0;
      end else if (key_code == PS2_BREAK) begin
        break_n = 1'b1;
      end else if (key_code != PS2_EXT) begin
        byte_ok = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (byte_ok) begin
          case (key_code)
            KEY_LEFT: begin
              if (xpos != '0) begin
                cand_x_n    = xpos - XW'(1);
                cand_y_n    = ypos;
                cand_rot_n  = rot;
                cand_down_n = 1'b0;
                state_n     = ST_CHECK;
              end
            end
            KEY_RIGHT: begin
              if (xpos < X_MAX) begin
                cand_x_n    = xpos + XW'(1);
                cand_y_n    = ypos;
                cand_rot_n  = rot;
                cand_down_n = 1'b0;
                state_n     = ST_CHECK;
              end
            end
            KEY_DOWN:  want_down = 1'b1;
            KEY_ROT: begin
              cand_x_n    = xpos;
              cand_y_n    = ypos;
              cand_rot_n  = rot + 2'd1;
              cand_down_n = 1'b0;
              state_n     = ST_CHECK;
            end
            KEY_PAUSE: state_n = ST_PAUSE;
            default:   ;
          endcase
        end else if (!key_valid && grav_pending) begin
          // Any key strobe this cycle takes priority; the drop waits.
          want_down = 1'b1;
          pend_n    = 1'b0;
        end

        if (want_down) begin
          if (ypos >= Y_MAX) begin
            state_n = ST_LOCK;
          end else begin
            cand_x_n    = xpos;
            cand_y_n    = ypos + YW'(1);
            cand_rot_n  = rot;
            cand_down_n = 1'b1;
            state_n     = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (check_ack) begin
          if (check_ok)       state_n = ST_COMMIT;
          else if (cand_down) state_n = ST_LOCK;
          else                state_n = ST_IDLE;
        end
      end

      ST_COMMIT: begin
        xpos_n  = cand_x;
        ypos_n  = cand_y;
        rot_n   = cand_rot;
        state_n = ST_IDLE;
      end

      ST_LOCK: begin
        xpos_n  = X_SPAWN;
        ypos_n  = '0;
        rot_n   = '0;
        state_n = ST_IDLE;
      end

      ST_PAUSE: begin
        if (byte_ok && (key_code == KEY_PAUSE)) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase

    // A wrap landing while an earlier tick is still pending merges into it.
    if (grav_tick) pend_n = 1'b1;
  end

  assign check_req  = (state == ST_CHECK);
  assign lock_pulse = (state == ST_LOCK);
  assign paused     = (state == ST_PAUSE);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

endmodule
